pixel_block_unpacker: RTL and testbench
=======================================

Name: pixel_block_unpacker

Overview:
- Return-path counterpart of the Nios pixel-line feeder.
- Takes the sixteen 32-bit result words that the Nios compression system drives on its line out-ports (Line1_1 through Line8_2) and captures them as one 8x8 block of 8-bit pixels.
- Replays the block as a raster-order byte stream with a valid/ready handshake, for downstream display or storage logic.
- Counts completed blocks.

Parameters:
- COUNT_W, 16: width of the completed-block counter (wraps).

Ports:
- clk  in  1  system clock, same clock as the Nios system.
- reset  in  1  asynchronous, active-low reset.
- lines_in  in  512  16 result words packed flat; word w = 2*(r-1)+(h-1) for LineR_H, occupying bits [32*w+31 : 32*w].
- blk_valid  in  1  Nios asserts when lines_in holds a complete result block.
- blk_ready  out  1  unpacker can accept a block.
- pix_data  out  8  current pixel.
- pix_row  out  3  row of current pixel, 0..7.
- pix_col  out  3  column of current pixel, 0..7.
- pix_valid  out  1  pix_data, pix_row and pix_col are valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_last  out  1  current pixel is index 63.
- blk_done  out  1  one-cycle pulse after the last pixel transfer.
- blk_count  out  COUNT_W  number of completed blocks, modulo 2^COUNT_W.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - State is IDLE; blk_ready=1.
  - pix_valid, pix_last and blk_done are 0.
  - pix_data, pix_row, pix_col, blk_count, the capture register and the pixel index are all 0.
- Pixel mapping: pixel p (0..63) has row = p>>3 and col = p&7. It is taken from lines_in[32*(p>>2) + 31 - 8*(p&3) -: 8]. So pixel 0 is bits 31:24 of word 0 (the MSB byte comes first), matching the forward packing.
- State machine IDLE / STREAM / DONE:
  - IDLE:
    - blk_ready=1 and pix_valid=0.
    - If blk_valid=1, capture all 512 bits into an internal register in that cycle, set the index to 0, and move to STREAM.
  - STREAM:
    - blk_ready=0 and pix_valid=1.
    - pix_data, pix_row and pix_col come from the captured register at the current index.
    - pix_last=1 when the index is 63.
    - A transfer occurs when pix_valid and pix_ready are both 1. On a transfer, the index increments.
    - A transfer at index 63 moves to DONE.
    - When pix_ready=0, all pix_* outputs hold stable.
  - DONE:
    - Lasts exactly one cycle. blk_done=1, blk_count increments, blk_ready=0, pix_valid=0.
    - Next state is IDLE.
- Registered outputs: the first pixel appears the cycle after acceptance, and output is one pixel per cycle under continuous pix_ready.
- Minimum block period is 66 cycles: accept, 64 pixel transfers, DONE. A block held on blk_valid is re-accepted in the first IDLE cycle.
- lines_in and blk_valid are ignored outside IDLE. Changes to lines_in during STREAM do not affect output.
- blk_count wraps from 2^COUNT_W-1 to 0 without a flag.
- Reset asserted mid-stream discards the partial block immediately. After release, the unit is in IDLE with the index at 0 and blk_count at 0.
- pix_ready asserted while pix_valid=0 has no effect.

Test Plan:
1. Reset pulse with arbitrary inputs -> blk_ready=1; pix_valid=0; pix_last=0; blk_done=0; blk_count=0.
2. Ramp block (pixel p = p), blk_valid high for 1 cycle, pix_ready=1 constant:
   - pix_data = 0x00..0x3F on 64 consecutive cycles, starting the cycle after acceptance.
   - (row,col) = (0,0)..(7,7); pix_last only with 0x3F.
   - blk_done one cycle after that; blk_count=1; blk_ready=1 the following cycle.
3. Backpressure: pix_ready=0 for 5 cycles when pix_data=0x0A -> 0x0A, row 1, col 2 held for all 5 cycles. Stream resumes with 0x0B, with no loss or duplication.
4. Change lines_in to all 0xFF and hold blk_valid=1 during STREAM of the ramp block:
   - Stream still outputs the ramp values.
   - The all-0xFF block is accepted in the first IDLE cycle after DONE.
   - The next stream is 64 x 0xFF; blk_count=2.
5. Assert reset while pix_data=0x14 -> outputs return to reset values asynchronously. The next block accepted streams from pixel 0; blk_count=0 before its completion.
6. COUNT_W=2, 5 back-to-back blocks -> blk_count sequence 1,2,3,0,1; blk_done pulses exactly 5 times, each 1 cycle wide.

Source files
------------

// File: rtl/pixel_block_unpacker.sv
// Captures a 16-word Nios result block as an 8x8 pixel tile and replays it
// as a raster-order byte stream with a valid/ready handshake.
module pixel_block_unpacker #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [511:0]       lines_in,
    input  logic               blk_valid,
    output logic               blk_ready,
    output logic [7:0]         pix_data,
    output logic [2:0]         pix_row,
    output logic [2:0]         pix_col,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               blk_done,
    output logic [COUNT_W-1:0] blk_count
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [511:0]       cap_q;
    logic [5:0]         idx_q;
    logic [COUNT_W-1:0] cnt_q;
    logic               capture;
    logic               xfer;
    logic               last_xfer;
    logic [8:0]         base;

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        xfer      = 1'b0;
        blk_ready = 1'b0;
        pix_valid = 1'b0;
        blk_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                pix_valid = 1'b1;
                xfer      = pix_ready;
                if (pix_ready && idx_q == 6'd63) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                blk_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign last_xfer = xfer && (idx_q == 6'd63);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cap_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cap_q <= lines_in;
                idx_q <= '0;
            end else if (xfer) begin
                idx_q <= idx_q + 6'd1;
            end
            // count becomes visible in the same cycle blk_done pulses
            if (last_xfer) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // MSB byte of each word is the lowest-numbered pixel
    assign base      = {idx_q[5:2], ~idx_q[1:0], 3'b000};
    assign pix_data  = cap_q[base +: 8];
    assign pix_row   = idx_q[5:3];
    assign pix_col   = idx_q[2:0];
    assign pix_last  = pix_valid && (idx_q == 6'd63);
    assign blk_count = cnt_q;

endmodule

// File: tb/tb_pixel_block_unpacker.sv
// Randomized bench for pixel_block_unpacker against a block-level model:
// expected pixels come from the 8x8 tile that was packed onto lines_in.
module tb_pixel_block_unpacker;

    typedef logic [7:0] blk_t [64];

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] lines_in;
    logic         blk_valid;
    logic         pix_ready;

    logic         blk_ready, pix_valid, pix_last, blk_done;
    logic [7:0]   pix_data;
    logic [2:0]   pix_row, pix_col;
    logic [15:0]  blk_count;

    logic         blk_ready_b, pix_valid_b, pix_last_b, blk_done_b;
    logic [7:0]   pix_data_b;
    logic [2:0]   pix_row_b, pix_col_b;
    logic [1:0]   blk_count_b;

    logic [17:0]  pixvec;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int blocks_done = 0;
    int done_seen = 0;

    pixel_block_unpacker #(.COUNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .lines_in  (lines_in),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .pix_data  (pix_data),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .blk_done  (blk_done),
        .blk_count (blk_count)
    );

    pixel_block_unpacker #(.COUNT_W(2)) dut_w2 (
        .clk       (clk),
        .reset     (reset),
        .lines_in  (lines_in),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready_b),
        .pix_data  (pix_data_b),
        .pix_row   (pix_row_b),
        .pix_col   (pix_col_b),
        .pix_valid (pix_valid_b),
        .pix_ready (pix_ready),
        .pix_last  (pix_last_b),
        .blk_done  (blk_done_b),
        .blk_count (blk_count_b)
    );

    always #5 clk = ~clk;

    assign pixvec = {pix_valid, pix_last, blk_ready, blk_done,
                     pix_row, pix_col, pix_data};

    always @(posedge clk) begin
        if (reset && blk_done_b) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] pack(input blk_t px);
        logic [511:0] v;
        v = '0;
        for (int p = 0; p < 64; p++) begin
            v[32*(p/4) + 31 - 8*(p%4) -: 8] = px[p];
        end
        return v;
    endfunction

    function automatic logic [511:0] rand_lines();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    task automatic send_block(input blk_t px, input int stall_pct,
                              input int stall_at, input logic [511:0] bg,
                              input bit bg_valid);
        int k;
        int cyc;
        int stalls;
        logic [5:0] kv;
        check("idle_pre", 32'({blk_done, pix_valid, blk_ready}), 32'h1);
        lines_in  = pack(px);
        blk_valid = 1'b1;
        pix_ready = 1'($urandom_range(1));
        @(negedge clk);
        k = 0;
        cyc = 0;
        stalls = 0;
        while (k < 64 && cyc < 1000) begin
            kv = k[5:0];
            check("pix", 32'(pixvec),
                  32'({1'b1, k == 63, 2'b00, kv[5:3], kv[2:0], px[k]}));
            if (bg_valid) begin
                lines_in  = bg;
                blk_valid = 1'b1;
            end else begin
                lines_in  = rand_lines();
                blk_valid = 1'($urandom_range(1));
            end
            if (k == stall_at && stalls < 5) begin
                pix_ready = 1'b0;
                stalls++;
            end else begin
                pix_ready = ($urandom_range(99) >= stall_pct);
            end
            @(posedge clk);
            if (pix_ready) k++;
            @(negedge clk);
            cyc++;
        end
        if (k < 64) check("stream_timeout", k, 64);
        if (stall_pct == 0)
            check("stream_cycles", cyc, 64 + (stall_at >= 0 ? 5 : 0));
        exp_cnt++;
        blocks_done++;
        check("done", 32'({pix_valid, pix_last, blk_ready, blk_done}), 32'h1);
        check("count", 32'(blk_count), exp_cnt & 32'hFFFF);
        check("count_w2", 32'(blk_count_b), exp_cnt & 32'h3);
        pix_ready = 1'($urandom_range(1));
        if (bg_valid) begin
            lines_in  = bg;
            blk_valid = 1'b1;
        end else begin
            blk_valid = 1'b0;
        end
        @(negedge clk);
        check("idle_post", 32'({pix_valid, blk_ready, blk_done}), 32'h2);
        check("count_hold", 32'(blk_count), exp_cnt & 32'hFFFF);
    endtask

    initial begin
        blk_t ramp, ffs, rb;
        logic [511:0] ff_lines;
        for (int i = 0; i < 64; i++) begin
            ramp[i] = 8'(i);
            ffs[i]  = 8'hFF;
        end
        ff_lines = pack(ffs);

        // reset with arbitrary inputs
        reset     = 1'b0;
        lines_in  = rand_lines();
        blk_valid = 1'b1;
        pix_ready = 1'b1;
        #13;
        check("rst_ctrl", 32'({pix_valid, pix_last, blk_ready, blk_done}), 32'h2);
        check("rst_pix", 32'({pix_row, pix_col, pix_data}), 32'h0);
        check("rst_count", 32'(blk_count), 32'h0);
        blk_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // ramp with pending all-0xFF block held during stream
        send_block(ramp, 0, -1, ff_lines, 1'b1);
        send_block(ffs, 0, -1, '0, 1'b0);
        check("count_two", 32'(blk_count), 32'h2);

        // backpressure at pixel 0x0A
        send_block(ramp, 0, 10, '0, 1'b0);

        // random blocks with random stalls, wraps the 2-bit counter
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 64; i++) rb[i] = 8'($urandom_range(255));
            send_block(rb, 30, -1, '0, 1'b0);
        end

        // reset in the middle of a stream
        lines_in  = pack(ramp);
        blk_valid = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_pix", 32'(pix_data), 32'h14);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'({pix_valid, pix_last, blk_ready, blk_done}), 32'h2);
        check("mid_rst_pix", 32'(pix_data), 32'h0);
        check("mid_rst_count", 32'({blk_count_b, blk_count}), 32'h0);
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_block(ramp, 0, -1, '0, 1'b0);

        check("done_pulses", done_seen, blocks_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
